// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types for the 8-bit ALU and the 16-bit op sequencer
package alu_pkg;

    typedef enum logic [1:0] {
        ADD16  = 2'd0,
        ADDSPE = 2'd1,
        INC16  = 2'd2,
        DEC16  = 2'd3
    } seq_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // F register upper nibble: Z N H C from msb to lsb
    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } flags_t;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_ADC = 5'd1,
        ALU_SUB = 5'd2,
        ALU_SBC = 5'd3,
        ALU_AND = 5'd4,
        ALU_XOR = 5'd5,
        ALU_OR  = 5'd6,
        ALU_CP  = 5'd7
    } alu_op_t;

endpackage

// File: rtl/alu16_sequencer.sv
// rtl/alu16_sequencer.sv - two-pass 16-bit ADD/ADDSPE/INC/DEC on the shared 8-bit ALU
// Optional ALU16_FAST_IDU_EN: INC16/DEC16 use an internal incrementer and finish in one cycle.
module alu16_sequencer
    import alu_pkg::*;
#(
    parameter bit BACK_TO_BACK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  seq_op_t     op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  flags_t      flags_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output flags_t      flags_out,
    output alu_op_t     alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output flags_t      alu_fin,
    input  logic [7:0]  alu_y,
    input  flags_t      alu_fout
);

    seq_state_t  state_q, state_d;
    seq_op_t     op_q, op_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    flags_t      fin_q, fin_d;
    flags_t      lo_f_q, lo_f_d;
    logic [15:0] result_q, result_d;
    flags_t      flags_out_q, flags_out_d;
    logic        accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= ADD16;
            opa_q       <= 16'h0000;
            opb_q       <= 16'h0000;
            fin_q       <= '0;
            lo_f_q      <= '0;
            result_q    <= 16'h0000;
            flags_out_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            fin_q       <= fin_d;
            lo_f_q      <= lo_f_d;
            result_q    <= result_d;
            flags_out_q <= flags_out_d;
        end
    end

    // A request is only seen from IDLE, or from DONE when back-to-back issue is allowed
    assign accept = start && ((state_q == IDLE) || ((state_q == DONE) && BACK_TO_BACK));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        fin_d       = fin_q;
        lo_f_d      = lo_f_q;
        result_d    = result_q;
        flags_out_d = flags_out_q;
        alu_op      = ALU_ADD;
        alu_a       = 8'h00;
        alu_b       = 8'h00;
        alu_fin     = '0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d    = op;
                    opa_d   = opa;
                    opb_d   = opb;
                    fin_d   = flags_in;
                    state_d = LO;
`ifdef ALU16_FAST_IDU_EN
                    if (op == INC16 || op == DEC16) begin
                        result_d    = (op == INC16) ? opa + 16'h0001 : opa - 16'h0001;
                        flags_out_d = flags_in;
                        state_d     = DONE;
                    end
`endif
                end
            end
            LO: begin
                alu_a   = opa_q[7:0];
                alu_fin = fin_q;
                case (op_q)
                    INC16:   alu_b = 8'h01;
                    DEC16: begin
                        alu_op = ALU_SUB;
                        alu_b  = 8'h01;
                    end
                    default: alu_b = opb_q[7:0];
                endcase
                result_d[7:0] = alu_y;
                lo_f_d        = alu_fout;
                state_d       = HI;
            end
            HI: begin
                alu_a     = opa_q[15:8];
                alu_fin   = fin_q;
                alu_fin.c = lo_f_q.c;
                alu_op    = ALU_ADC;
                flags_out_d = fin_q;
                case (op_q)
                    ADD16: begin
                        alu_b         = opb_q[15:8];
                        flags_out_d.n = 1'b0;
                        flags_out_d.h = alu_fout.h;
                        flags_out_d.c = alu_fout.c;
                    end
                    ADDSPE: begin
                        alu_b       = {8{opb_q[7]}};
                        flags_out_d = '{z: 1'b0, n: 1'b0, h: lo_f_q.h, c: lo_f_q.c};
                    end
                    INC16:   alu_b = 8'h00;
                    default: alu_op = ALU_SBC;
                endcase
                result_d[15:8] = alu_y;
                state_d        = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == LO) || (state_q == HI);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign flags_out = flags_out_q;

endmodule

// File: tb/tb_alu16_sequencer.sv
// tb/tb_alu16_sequencer.sv - scoreboard bench for alu16_sequencer with a behavioural 8-bit ALU
module tb_alu16_sequencer;
    import alu_pkg::*;

`ifdef ALU16_FAST_IDU_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    seq_op_t     op = ADD16;
    logic [15:0] opa = 16'h0000;
    logic [15:0] opb = 16'h0000;
    flags_t      flags_in = '0;
    logic        busy, done;
    logic [15:0] result;
    flags_t      flags_out;
    alu_op_t     alu_op;
    logic [7:0]  alu_a, alu_b;
    flags_t      alu_fin;
    logic [7:0]  alu_y;
    flags_t      alu_fout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  fl;
        int          at;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    alu16_sequencer #(.BACK_TO_BACK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .flags_in(flags_in), .busy(busy), .done(done), .result(result),
        .flags_out(flags_out), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_fin(alu_fin), .alu_y(alu_y), .alu_fout(alu_fout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference 8-bit ALU, combinational
    always_comb begin
        logic [8:0] s;
        logic [4:0] hn;
        logic       ci;
        ci = (alu_op == ALU_ADC || alu_op == ALU_SBC) ? alu_fin.c : 1'b0;
        s = 9'h0;
        hn = 5'h0;
        alu_fout = '0;
        if (alu_op == ALU_SUB || alu_op == ALU_SBC) begin
            s  = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, ci};
            hn = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'h0, ci};
            alu_fout.n = 1'b1;
        end else begin
            s  = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, ci};
            hn = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, ci};
        end
        alu_y = s[7:0];
        alu_fout.z = (s[7:0] == 8'h00);
        alu_fout.h = hn[4];
        alu_fout.c = s[8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_result"}, {16'h0, result}, {16'h0, e.res});
                check({e.name, "_flags"}, {28'h0, flags_out}, {28'h0, e.fl});
                check({e.name, "_cycle"}, cyc, e.at);
            end
        end
        if (rst_n && !busy)
            check("alu_idle", {19'h0, alu_op, alu_a, alu_b}, {19'h0, ALU_ADD, 16'h0000});
    end

    // Drives one request in the current cycle and leaves start low afterwards
    task automatic issue(input string name, input seq_op_t o, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] f,
                         input logic [15:0] er, input logic [3:0] ef, input bit push);
        int lat;
        lat = (FAST && (o == INC16 || o == DEC16)) ? 1 : 3;
        op = o; opa = a; opb = b; flags_in = f; start = 1'b1;
        if (push) exp_q.push_back('{res: er, fl: ef, at: cyc + lat, name: name});
        @(negedge clk);
        start = 1'b0; opa = 16'hA5A5; opb = 16'h5A5A; flags_in = 4'b0101; op = DEC16;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 12) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0) begin
            check("timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2;
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_result", {16'h0, result}, 32'h0);
        check("rst_flags", {28'h0, flags_out}, 32'h0);
        check("rst_alu", {19'h0, alu_op, alu_a, alu_b}, {19'h0, ALU_ADD, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue("add_hcarry", ADD16, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010, 1'b1);
        #2 check("busy_c1", {31'h0, busy}, 32'd1);
        @(negedge clk);
        #2 check("busy_c2", {31'h0, busy}, 32'd1);
        wait_idle();

        issue("add_wrap", ADD16, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011, 1'b1);
        wait_idle();
        issue("add_mid", ADD16, 16'h8A23, 16'h0605, 4'b0000, 16'h9028, 4'b0010, 1'b1);
        wait_idle();
        issue("spe_pos", ADDSPE, 16'hFFF8, 16'h0008, 4'b1100, 16'h0000, 4'b0011, 1'b1);
        wait_idle();
        issue("spe_neg", ADDSPE, 16'h0005, 16'h00FF, 4'b1000, 16'h0004, 4'b0011, 1'b1);
        wait_idle();
        issue("dec_wrap", DEC16, 16'h0000, 16'h1234, 4'b1011, 16'hFFFF, 4'b1011, 1'b1);
        wait_idle();
        issue("inc_wrap", INC16, 16'hFFFF, 16'h0000, 4'b0100, 16'h0000, 4'b0100, 1'b1);
        wait_idle();
        issue("inc_carry", INC16, 16'h12FF, 16'h0000, 4'b0000, 16'h1300, 4'b0000, 1'b1);
        wait_idle();
        issue("dec_borrow", DEC16, 16'h1200, 16'h0000, 4'b0010, 16'h11FF, 4'b0010, 1'b1);
        wait_idle();

        // Request while busy must be dropped; a stray done would hit an empty scoreboard
        issue("busy_base", ADD16, 16'h0102, 16'h0304, 4'b0000, 16'h0406, 4'b0000, 1'b1);
        op = ADD16; opa = 16'h1111; opb = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        // Back-to-back: second start held during the DONE cycle
        issue("b2b_first", ADD16, 16'h00F0, 16'h0010, 4'b0000, 16'h0100, 4'b0000, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2 check("b2b_in_done", {31'h0, done}, 32'd1);
        issue("b2b_second", ADD16, 16'h7FFF, 16'h0001, 4'b0000, 16'h8000, 4'b0010, 1'b1);
        #2 check("b2b_lo_next", {31'h0, busy}, 32'd1);
        wait_idle();

        // Reset in the HI cycle
        issue("rst_mid", ADD16, 16'h1234, 16'h1111, 4'b1111, 16'h0, 4'h0, 1'b0);
        @(negedge clk);
        #2 check("pre_rst_busy", {31'h0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'h0, busy}, 32'd0);
        check("midrst_done", {31'h0, done}, 32'd0);
        check("midrst_result", {16'h0, result}, 32'h0);
        check("midrst_flags", {28'h0, flags_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("leftover_expected", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
